// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces one key at a time and
// reports its hex code with a one-cycle strobe plus a held-down level.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);
    // indexed by {row, col}; row3 carries '*'=E and '#'=F
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state, state_nx;
    logic [3:0]    sync1, col_s, pat, pat_nx;
    logic [1:0]    row, row_nx, col_idx;
    logic [SW-1:0] slot, slot_nx;
    logic [DW-1:0] cnt, cnt_nx;
    logic [3:0]    code_nx;
    logic          valid_nx, down_nx, accept, done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 4'hF;
            col_s     <= 4'hF;
            state     <= SCAN;
            row       <= '0;
            slot      <= '0;
            cnt       <= '0;
            pat       <= 4'hF;
            row_out   <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            sync1     <= col_in;
            col_s     <= sync1;
            state     <= state_nx;
            row       <= row_nx;
            slot      <= slot_nx;
            cnt       <= cnt_nx;
            pat       <= pat_nx;
            row_out   <= ~(4'b0001 << row_nx);
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_down  <= down_nx;
        end
    end

    always_comb begin
        state_nx = state;
        row_nx   = row;
        slot_nx  = slot;
        cnt_nx   = cnt;
        pat_nx   = pat;
        case (state)
            SCAN: begin
                slot_nx = (slot == SLOT_LAST) ? '0 : slot + SW'(1);
                if (slot == SLOT_LAST && col_s != 4'hF) begin
                    state_nx = DEBOUNCE;
                    pat_nx   = col_s;
                    cnt_nx   = '0;
                end else if (slot == SLOT_LAST) begin
                    row_nx = row + 2'd1;
                end
            end
            DEBOUNCE: begin
                state_nx = (col_s != pat) ? SCAN : (cnt == DEB_LAST) ? PRESSED : DEBOUNCE;
                cnt_nx   = (col_s == pat && cnt != DEB_LAST) ? cnt + DW'(1) : cnt;
            end
            PRESSED: begin
                state_nx = (col_s == 4'hF) ? RELEASE : PRESSED;
                cnt_nx   = '0;
            end
            RELEASE: begin
                state_nx = (col_s != 4'hF) ? PRESSED : (cnt == DEB_LAST) ? SCAN : RELEASE;
                cnt_nx   = (col_s == 4'hF && cnt != DEB_LAST) ? cnt + DW'(1) : '0;
                row_nx   = (col_s == 4'hF && cnt == DEB_LAST) ? row + 2'd1 : row;
                slot_nx  = '0;
            end
            default: state_nx = SCAN;
        endcase
    end

    // lowest low column wins when several keys share the frozen row
    assign col_idx = !pat[0] ? 2'd0 : !pat[1] ? 2'd1 : !pat[2] ? 2'd2 : 2'd3;
    assign accept  = state == DEBOUNCE && col_s == pat && cnt == DEB_LAST;
    assign done    = state == RELEASE && col_s == 4'hF && cnt == DEB_LAST;

    always_comb begin
        code_nx  = accept ? KEYMAP[{row, col_idx}] : key_code;
        valid_nx = accept;
        down_nx  = accept ? 1'b1 : done ? 1'b0 : key_down;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated key matrix and compares every cycle against
// a phase-by-phase reference model, plus directed checks of latencies and key codes.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 8;
    localparam int DEB      = 16;
    localparam logic [3:0] KEYS [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_in = 4'hF;
    logic [3:0] row_out, key_code;
    logic       key_valid, key_down;

    int         n_cmp = 0, n_bad = 0, nvalid = 0;
    bit         held [16];
    logic [3:0] force_low = 4'h0;
    bit         rnd_cols = 1'b0;

    logic [3:0] e_row = 4'b1110, e_code = 4'h0;
    logic       e_valid = 1'b0, e_down = 1'b0;
    bit         ab;
    logic [3:0] hist [$];

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] matrix_cols();
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (held[r*4+k] && !row_out[r]) c[k] = 1'b0;
        return c & ~force_low;
    endfunction

    function automatic logic [3:0] code_of(input int r, input logic [3:0] pat);
        for (int k = 0; k < 4; k++)
            if (!pat[k]) return KEYS[r*4+k];
        return 4'h0;
    endfunction

    // keypad pins: columns follow the driven row, changed well away from the sampling edge
    initial forever begin
        @(negedge clk);
        #2;
        col_in = rnd_cols ? 4'($urandom) : matrix_cols();
    end

    // one clock of the model; cs is the column value the scanner sees at this edge
    task automatic tk(output logic [3:0] cs);
        @(posedge clk);
        e_valid = 1'b0;
        if (!rst_n) begin
            ab = 1'b1;
            hist.delete();
            e_row = 4'b1110;
            e_code = 4'h0;
            e_down = 1'b0;
            cs = 4'hF;
            return;
        end
        hist.push_back(col_in);
        cs = (hist.size() >= 3) ? hist[hist.size()-3] : 4'hF;
        if (hist.size() > 3) void'(hist.pop_front());
    endtask

    initial begin : ref_model
        int r;
        logic [3:0] cs, pat;
        bit ok;
        forever begin
            ab = 1'b0;
            r = 0;
            while (!ab) begin
                for (int s = 0; s < SCAN_DIV && !ab; s++) tk(cs);
                if (ab) break;
                if (cs == 4'hF) begin
                    r = (r + 1) % 4;
                    e_row = ~(4'b0001 << r);
                    continue;
                end
                pat = cs;
                ok = 1'b1;
                for (int n = 0; n < DEB && ok && !ab; n++) begin
                    tk(cs);
                    ok = (cs == pat);
                end
                if (ab) break;
                if (!ok) continue;
                e_code = code_of(r, pat);
                e_valid = 1'b1;
                e_down = 1'b1;
                ok = 1'b0;
                while (!ab && !ok) begin
                    cs = 4'h0;
                    while (!ab && cs != 4'hF) tk(cs);
                    ok = 1'b1;
                    for (int n = 0; n < DEB && ok && !ab; n++) begin
                        tk(cs);
                        ok = (cs == 4'hF);
                    end
                end
                if (ab) break;
                e_down = 1'b0;
                r = (r + 1) % 4;
                e_row = ~(4'b0001 << r);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        check("row_out", row_out, e_row);
        check("key_code", key_code, e_code);
        check("key_valid", key_valid, e_valid);
        check("key_down", key_down, e_down);
        if (key_valid) nvalid++;
    end

    task automatic wait_valid(input string tag, input int max);
        int n0, k;
        n0 = nvalid;
        k = 0;
        while (nvalid == n0 && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, nvalid != n0, 1);
    endtask

    task automatic wait_release(input string tag, input int max);
        int k;
        k = 0;
        while (key_down && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, key_down, 0);
    endtask

    initial begin
        int n0, k;
        logic [3:0] exp_row;
        rnd_cols = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_row", row_out, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 0);
        check("rst_down", key_down, 0);
        rnd_cols = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            exp_row = ~(4'b0001 << (((i + 1) / SCAN_DIV) % 4));
            check("idle_row", row_out, exp_row);
        end
        @(negedge clk);

        n0 = nvalid;
        held[5] = 1'b1;
        repeat (100) @(negedge clk);
        check("p5_pulses", nvalid - n0, 1);
        check("p5_code", key_code, 4'h5);
        check("p5_down", key_down, 1);
        held[5] = 1'b0;
        k = 0;
        while (key_down && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        // two synchroniser cycles, one to notice the release, then the full count
        check("p5_rel_lat", k, DEB + 3);
        check("p5_next_row", row_out, 4'b1011);
        @(negedge clk);

        k = 0;
        while (row_out != 4'b1110 && k < 64) begin @(negedge clk); k++; end
        while (row_out == 4'b1110 && k < 64) begin @(negedge clk); k++; end
        check("bounce_row1", row_out, 4'b1101);
        n0 = nvalid;
        held[5] = 1'b1;
        repeat (10) @(negedge clk);
        held[5] = 1'b0;
        repeat (40) @(negedge clk);
        check("bounce_pulses", nvalid - n0, 0);
        check("bounce_code", key_code, 4'h5);
        held[14] = 1'b1;
        wait_valid("hash_valid", 100);
        check("hash_code", key_code, 4'hF);
        held[14] = 1'b0;
        wait_release("hash_release", 80);

        held[0] = 1'b1;
        held[2] = 1'b1;
        wait_valid("two_valid", 100);
        check("two_code", key_code, 4'h1);
        n0 = nvalid;
        held[9] = 1'b1;
        repeat (60) @(negedge clk);
        check("second_pulses", nvalid - n0, 0);
        check("second_code", key_code, 4'h1);
        held[9] = 1'b0;
        held[2] = 1'b0;
        repeat (5) @(negedge clk);

        held[0] = 1'b0;
        repeat (11) @(negedge clk);
        force_low = 4'b0001;
        repeat (3) @(negedge clk);
        force_low = 4'h0;
        repeat (7) @(negedge clk);
        check("chatter_hold", key_down, 1);
        repeat (11) @(negedge clk);
        check("chatter_restart", key_down, 1);
        @(negedge clk);
        check("chatter_fall", key_down, 0);

        held[13] = 1'b1;
        wait_valid("zero_valid", 100);
        check("zero_code", key_code, 4'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_row", row_out, 4'b1110);
        check("midrst_down", key_down, 0);
        check("midrst_valid", key_valid, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_valid("redetect_valid", 100);
        check("redetect_code", key_code, 4'h0);
        check("redetect_down", key_down, 1);
        held[13] = 1'b0;
        wait_release("redetect_release", 80);

        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 15);
            held[k] = 1'b1;
            if ($urandom_range(0, 3) == 0) held[$urandom_range(0, 15)] = 1'b1;
            repeat ($urandom_range(3, 70)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                force_low = 4'($urandom);
                repeat ($urandom_range(1, 4)) @(negedge clk);
                force_low = 4'h0;
            end
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end
            for (int j = 0; j < 16; j++) held[j] = 1'b0;
            repeat ($urandom_range(5, 60)) @(negedge clk);
        end
        repeat (50) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
